// File: rtl/lsu_ram_ctrl_if.sv
// rtl/lsu_ram_ctrl_if.sv - request/response and data-RAM signal bundle for lsu_ram_ctrl
interface lsu_ram_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_we;
  logic [31:0]       ram_wd;
  logic [31:0]       ram_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_a, ram_we, ram_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_a, ram_we, ram_wd
  );
endinterface

// File: rtl/lsu_ram_ctrl.sv
// rtl/lsu_ram_ctrl.sv - load/store unit driving a word RAM with RMW stores and split misaligned accesses
module lsu_ram_ctrl #(
  parameter int ADDR_W      = 32,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_ram_ctrl_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [31:0]       buf0_q, buf0_d;
  logic [31:0]       buf1_q, buf1_d;
  logic [31:0]       rdata_q, rdata_d;

  // A halfword at offset 3 or a word at any nonzero offset touches two RAM words.
  function automatic logic is_span(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b10) && (off != 2'b00)) || ((f3[1:0] == 2'b01) && (off == 2'b11));
  endfunction

  function automatic logic is_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3[2] || (f3[1:0] == 2'b11);
    return (f3[1:0] == 2'b11) || (f3 == 3'b110);
  endfunction

  logic              span;
  logic [ADDR_W-1:0] w0, w1;
  logic [31:0]       lo_word, hi_word, shifted, load_val;
  logic [3:0]        mask4;
  logic [7:0]        mask8;
  logic [63:0]       data64, old64, merged;

  // Datapath: word addresses, load extraction/extension and store byte merge.
  always_comb begin
    span    = is_span(funct3_q, addr_q[1:0]);
    w0      = {addr_q[ADDR_W-1:2], 2'b00};
    w1      = w0 + ADDR_W'(4);
    // In RD1 the low word is already buffered and the high word is on ram_rd;
    // in RD0 only the current word is needed (non-spanning loads).
    lo_word = (state_q == S_RD1) ? buf0_q : bus.ram_rd;
    hi_word = (state_q == S_RD1) ? bus.ram_rd : 32'h0;
    shifted = 32'({hi_word, lo_word} >> {addr_q[1:0], 3'b000});
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = shifted;
    endcase
    case (funct3_q[1:0])
      2'b00:   mask4 = 4'h1;
      2'b01:   mask4 = 4'h3;
      default: mask4 = 4'hF;
    endcase
    mask8  = {4'h0, mask4} << addr_q[1:0];
    data64 = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
    old64  = {buf1_q, buf0_q};
    merged = old64;
    for (int i = 0; i < 8; i++) begin
      if (mask8[i]) merged[8*i +: 8] = data64[8*i +: 8];
    end
  end

  // Next-state and per-state bus outputs.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    funct3_d       = funct3_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    buf0_d         = buf0_q;
    buf1_d         = buf1_q;
    rdata_d        = rdata_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.ram_a      = '0;
    bus.ram_we     = 1'b0;
    bus.ram_wd     = 32'h0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          funct3_d = bus.req_funct3;
          we_d     = bus.req_we;
          wdata_d  = bus.req_wdata;
          err_d    = is_illegal(bus.req_we, bus.req_funct3) ||
                     (!MISALIGN_EN && is_span(bus.req_funct3, bus.req_addr[1:0]));
          if (err_d) begin
            rdata_d = 32'h0;
            state_d = S_DONE;
          end else begin
            state_d = S_RD0;
          end
        end
      end
      S_RD0: begin
        bus.ram_a = w0;
        buf0_d    = bus.ram_rd;
        buf1_d    = 32'h0;
        if (span) begin
          state_d = S_RD1;
        end else if (we_q) begin
          state_d = S_WR0;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_RD1: begin
        bus.ram_a = w1;
        buf1_d    = bus.ram_rd;
        if (we_q) begin
          state_d = S_WR0;
        end else begin
          rdata_d = load_val;
          state_d = S_DONE;
        end
      end
      S_WR0: begin
        bus.ram_a  = w0;
        bus.ram_we = 1'b1;
        bus.ram_wd = merged[31:0];
        state_d    = span ? S_WR1 : S_DONE;
      end
      S_WR1: begin
        bus.ram_a  = w1;
        bus.ram_we = 1'b1;
        bus.ram_wd = merged[63:32];
        state_d    = S_DONE;
      end
      S_DONE: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.resp_rdata = rdata_q;

  // State and latched-request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= 3'b000;
      we_q     <= 1'b0;
      wdata_q  <= 32'h0;
      err_q    <= 1'b0;
      buf0_q   <= 32'h0;
      buf1_q   <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
